maxnet_job_loader: RTL

Front-end sequencer for the four-neuron Maxnet datapath. It accepts a job as a stream of five 32-bit IEEE-754 words, presents them as stable parallel operands, and pulses the datapath start. It then waits for the datapath's finish indication, with a cycle count and timeout, and returns the winner value to the host over a valid/ready response channel.

---
 rtl/maxnet_job_loader.sv | 113 +++++++++++
 1 files changed

// File: rtl/maxnet_job_loader.sv
// Job loader for the four-neuron Maxnet datapath: collects five operand words,
// starts the datapath, waits for its finish (with timeout) and returns the winner.
module maxnet_job_loader #(
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  output logic [31:0]      a1_init,
  output logic [31:0]      a2_init,
  output logic [31:0]      a3_init,
  output logic [31:0]      a4_init,
  output logic [31:0]      epsilon,
  output logic             nn_start,
  input  logic             nn_finish,
  input  logic [31:0]      nn_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_data,
  output logic             m_error,
  output logic [CNT_W-1:0] m_cycles,
  output logic             busy
);

  typedef enum logic [1:0] {LOAD, START, WAIT, RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  state_t           state;
  logic [2:0]       wc;
  logic [CNT_W-1:0] cnt;
  logic             armed;

  assign s_ready = (state == LOAD) & ~rst;
  assign busy    = (state != LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD;
      wc       <= 3'd0;
      cnt      <= '0;
      armed    <= 1'b0;
      a1_init  <= 32'd0;
      a2_init  <= 32'd0;
      a3_init  <= 32'd0;
      a4_init  <= 32'd0;
      epsilon  <= 32'd0;
      nn_start <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= 32'd0;
      m_error  <= 1'b0;
      m_cycles <= '0;
    end else begin
      nn_start <= 1'b0;
      case (state)
        LOAD: begin
          if (s_valid && s_ready) begin
            case (wc)
              3'd0:    a1_init <= s_data;
              3'd1:    a2_init <= s_data;
              3'd2:    a3_init <= s_data;
              3'd3:    a4_init <= s_data;
              default: epsilon <= s_data;
            endcase
            if (wc == 3'd4) begin
              wc       <= 3'd0;
              state    <= START;
              nn_start <= 1'b1;
            end else begin
              wc <= wc + 3'd1;
            end
          end
        end
        START: begin
          cnt   <= '0;
          armed <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          // A finish level only counts once it has been seen low in this job.
          if (!nn_finish) armed <= 1'b1;
          if (armed && nn_finish) begin
            m_data   <= nn_out;
            m_error  <= 1'b0;
            m_cycles <= cnt + 1'b1;
            m_valid  <= 1'b1;
            state    <= RESP;
          end else if (cnt == CNT_LAST) begin
            m_data   <= 32'd0;
            m_error  <= 1'b1;
            m_cycles <= CNT_LIMIT;
            m_valid  <= 1'b1;
            state    <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
